if_id_buffer: RTL and testbench

- Fetch-to-decode stage that captures each fetched {PC, instruction} pair.
- Sits between the PC register / instruction memory and the decode stage.
- Holds up to two fetched words in a skid buffer so a decode stall never loses an in-flight fetch.
- Drives the PC register's advance enable and supports flush on redirect (exception/eret).

---
 rtl/if_id_buffer.sv | 164 ++++++++++++++++
 tb/tb_if_id_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//
// Fetch-to-decode stage.  Captures each fetched {pc, instr} pair in a
// 2-entry skid FIFO so that a decode stall never loses a word already
// fetched, drives the PC register's advance enable, and empties itself on
// a redirect flush.
//
// Optional feature (macro IF_ADEL_CHECK_EN): when defined, each enqueued
// fetch address is range/alignment checked; an illegal address is stored
// as a NOP with exception code EXC_ADEL.  When undefined, the instruction
// is stored unchanged, exc is always 0 and no comparators are built.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   pc_in        current PC from the PC register
//   instr_in     instruction word read combinationally at pc_in
//   fetch_valid  pc_in/instr_in hold a valid fetch this cycle
//   flush        discard all buffered and incoming words (redirect)
//   id_ready     decode accepts the head word this cycle
//   pc_en        enable to the PC register (advance or load redirect)
//   valid_out    head entry valid
//   pc_out       PC of the head entry (0 when empty)
//   pc8_out      pc_out + 8, link address for jal/jalr
//   instr_out    instruction of the head entry (0 = NOP when empty)
//   exc_out      exception code of the head entry, 0 = none
//   count_out    occupancy, 0..2
// ---------------------------------------------------------------------------
module if_id_buffer #(
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        fetch_valid,
    input  logic        flush,
    input  logic        id_ready,
    output logic        pc_en,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc8_out,
    output logic [31:0] instr_out,
    output logic [4:0]  exc_out,
    output logic [1:0]  count_out
);

    logic [31:0] pc_mem_r    [2];
    logic [31:0] instr_mem_r [2];
    logic [4:0]  exc_mem_r   [2];
    logic        head_r;
    logic        tail_r;
    logic [1:0]  count_r;

    logic        in_ready_s;
    logic        enq_s;
    logic        deq_s;
    logic [31:0] wr_instr_s;
    logic [4:0]  wr_exc_s;

    // Readiness looks only at the registered count: a full buffer refuses
    // the incoming word even if decode pops in the same cycle.
    assign in_ready_s = (count_r < 2'd2);
    assign valid_out  = (count_r != 2'd0);
    assign enq_s      = fetch_valid & in_ready_s & ~flush & ~reset;
    assign deq_s      = valid_out & id_ready & ~flush & ~reset;
    assign pc_en      = ~reset & (flush | (fetch_valid & in_ready_s));
    assign count_out  = count_r;

`ifdef IF_ADEL_CHECK_EN
    logic adel_s;
    logic unused_cfg_s;
    assign unused_cfg_s = 1'b0;

    // Illegal fetch address: misaligned or outside the instruction window.
    always_comb begin
        adel_s = 1'b0;
        if ((pc_in[1:0] != 2'b00) || (pc_in < PC_LO) || (pc_in > PC_HI)) begin
            adel_s = 1'b1;
        end else begin
            adel_s = 1'b0;
        end
    end

    // A faulty word is stored as a NOP tagged with the address-error code.
    always_comb begin
        wr_instr_s = instr_in;
        wr_exc_s   = 5'd0;
        if (adel_s) begin
            wr_instr_s = 32'h0000_0000;
            wr_exc_s   = EXC_ADEL;
        end else begin
            wr_instr_s = instr_in;
            wr_exc_s   = 5'd0;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{PC_LO, PC_HI, EXC_ADEL};

    // Without address checking the fetched word is stored as-is.
    always_comb begin
        wr_instr_s = instr_in;
        wr_exc_s   = 5'd0;
    end
`endif

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
                exc_mem_r[i]   <= 5'd0;
            end
        end else if (flush) begin
            // Entry contents are left stale; count=0 hides them.
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq_s) begin
                pc_mem_r[tail_r]    <= pc_in;
                instr_mem_r[tail_r] <= wr_instr_s;
                exc_mem_r[tail_r]   <= wr_exc_s;
                tail_r              <= ~tail_r;
            end
            if (deq_s) begin
                head_r <= ~head_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; an empty buffer shows a zero NOP.
    always_comb begin
        pc_out    = 32'h0000_0000;
        instr_out = 32'h0000_0000;
        exc_out   = 5'd0;
        if (valid_out) begin
            pc_out    = pc_mem_r[head_r];
            instr_out = instr_mem_r[head_r];
            exc_out   = exc_mem_r[head_r];
        end else begin
            pc_out    = 32'h0000_0000;
            instr_out = 32'h0000_0000;
            exc_out   = 5'd0;
        end
    end

    // Link address, wraps modulo 2^32.
    assign pc8_out = pc_out + 32'd8;

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//
// Directed self-checking bench for if_id_buffer.  Inputs change #1 after a
// rising edge; registered state and the combinational pc_en are observed
// in that quiet window, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        fetch_valid;
    logic        flush;
    logic        id_ready;
    logic        pc_en;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] pc8_out;
    logic [31:0] instr_out;
    logic [4:0]  exc_out;
    logic [1:0]  count_out;

    int total = 0;
    int bad   = 0;

    if_id_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .id_ready   (id_ready),
        .pc_en      (pc_en),
        .valid_out  (valid_out),
        .pc_out     (pc_out),
        .pc8_out    (pc8_out),
        .instr_out  (instr_out),
        .exc_out    (exc_out),
        .count_out  (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [4:0] exc,
                            input logic [1:0] cnt);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        chk({tag, ".pc"},    pc_out, pc);
        chk({tag, ".pc8"},   pc8_out, pc + 32'd8);
        chk({tag, ".instr"}, instr_out, ins);
        chk({tag, ".exc"},   {27'd0, exc_out}, {27'd0, exc});
        chk({tag, ".count"}, {30'd0, count_out}, {30'd0, cnt});
    endtask

    // Enqueue one word with decode stalled, then leave fetch idle.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] ins);
        id_ready    = 1'b0;
        fetch_valid = 1'b1;
        pc_in       = pc;
        instr_in    = ins;
        tick();
        fetch_valid = 1'b0;
    endtask

    // Pop the head word and confirm the buffer is empty again.
    task automatic pop_one(input string tag);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk({tag, ".drained"}, {30'd0, count_out}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; pc_in = 32'h0; instr_in = 32'h0;
        fetch_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
        tick();
        tick();
        chk("rst.pc8", pc8_out, 32'h0000_0008);
        chk_head("rst", 1'b0, 32'h0, 32'h0, 5'd0, 2'd0);
        fetch_valid = 1'b1; pc_in = 32'h3000;
        #1;
        chk("rst.pc_en", {31'd0, pc_en}, 32'd0);
        fetch_valid = 1'b0;
        reset = 1'b0;
        tick();

        // 1: single word, one-cycle latency, then consumed
        fetch_valid = 1'b1; id_ready = 1'b1; pc_in = 32'h3000; instr_in = 32'h2408_0001;
        #1;
        chk("t1.pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        fetch_valid = 1'b0;
        chk_head("t1.head", 1'b1, 32'h3000, 32'h2408_0001, 5'd0, 2'd1);
        tick();
        chk_head("t1.empty", 1'b0, 32'h0, 32'h0, 5'd0, 2'd0);

        // 2: stall, fill to 2, third word refused
        id_ready = 1'b0; fetch_valid = 1'b1; pc_in = 32'h3000; instr_in = 32'hA000_0000;
        tick();
        chk("t2.cnt1", {30'd0, count_out}, 32'd1);
        pc_in = 32'h3004; instr_in = 32'hA000_0001;
        #1;
        chk("t2.pc_en1", {31'd0, pc_en}, 32'd1);
        tick();
        chk_head("t2.full", 1'b1, 32'h3000, 32'hA000_0000, 5'd0, 2'd2);
        pc_in = 32'h3008; instr_in = 32'hA000_0002;
        #1;
        chk("t2.pc_en_full", {31'd0, pc_en}, 32'd0);
        tick();
        chk_head("t2.hold", 1'b1, 32'h3000, 32'hA000_0000, 5'd0, 2'd2);

        // 3: full + decode ready -> one pop, no push; push resumes next cycle
        id_ready = 1'b1;
        #1;
        chk("t3.pc_en_full", {31'd0, pc_en}, 32'd0);
        tick();
        chk_head("t3.pop", 1'b1, 32'h3004, 32'hA000_0001, 5'd0, 2'd1);
        chk("t3.pc_en_resume", {31'd0, pc_en}, 32'd1);
        tick();
        fetch_valid = 1'b0;
        chk_head("t3.next", 1'b1, 32'h3008, 32'hA000_0002, 5'd0, 2'd1);
        tick();
        chk("t3.drained", {30'd0, count_out}, 32'd0);

        // 4: flush with a full buffer and an incoming word
        id_ready = 1'b0; fetch_valid = 1'b1; pc_in = 32'h3100; instr_in = 32'hB000_0000;
        tick();
        pc_in = 32'h3104; instr_in = 32'hB000_0001;
        tick();
        chk("t4.full", {30'd0, count_out}, 32'd2);
        flush = 1'b1; id_ready = 1'b1; pc_in = 32'h4000; instr_in = 32'hB000_0002;
        #1;
        chk("t4.pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        flush = 1'b0; id_ready = 1'b0;
        chk_head("t4.flushed", 1'b0, 32'h0, 32'h0, 5'd0, 2'd0);
        pc_in = 32'h4180; instr_in = 32'hC000_0000;
        tick();
        fetch_valid = 1'b0;
        chk_head("t4.after", 1'b1, 32'h4180, 32'hC000_0000, 5'd0, 2'd1);
        tick();
        chk_head("t4.alone", 1'b1, 32'h4180, 32'hC000_0000, 5'd0, 2'd1);
        pop_one("t4");
        flush = 1'b1;
        #1;
        chk("t4.empty_flush_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        flush = 1'b0;
        chk_head("t4.empty_flush", 1'b0, 32'h0, 32'h0, 5'd0, 2'd0);

        // 5: reset mid-stream with 2 buffered words
        fetch_valid = 1'b1; pc_in = 32'h3000; instr_in = 32'hD000_0000;
        tick();
        pc_in = 32'h3004; instr_in = 32'hD000_0001;
        tick();
        chk("t5.full", {30'd0, count_out}, 32'd2);
        reset = 1'b1;
        #1;
        chk("t5.pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        reset = 1'b0; fetch_valid = 1'b0;
        chk_head("t5.rst", 1'b0, 32'h0, 32'h0, 5'd0, 2'd0);
        id_ready = 1'b1;
        tick();
        chk("t5.never.valid", {31'd0, valid_out}, 32'd0);
        chk("t5.never.pc", pc_out, 32'h0);
        id_ready = 1'b0;

        // 6: address check (feature-dependent) and pc8 wrap
`ifdef IF_ADEL_CHECK_EN
        fetch_one(32'h3002, 32'hFFFF_FFFF);
        chk_head("t6.misal", 1'b1, 32'h3002, 32'h0, 5'd4, 2'd1);
        pop_one("t6.misal");
        fetch_one(32'h7000, 32'h1234_5678);
        chk_head("t6.high", 1'b1, 32'h7000, 32'h0, 5'd4, 2'd1);
        pop_one("t6.high");
        fetch_one(32'h2FFC, 32'h1234_5678);
        chk_head("t6.low", 1'b1, 32'h2FFC, 32'h0, 5'd4, 2'd1);
        pop_one("t6.low");
        fetch_one(32'h6FFC, 32'h1111_2222);
        chk_head("t6.top", 1'b1, 32'h6FFC, 32'h1111_2222, 5'd0, 2'd1);
        pop_one("t6.top");
        fetch_one(32'h3004, 32'h3333_4444);
        chk_head("t6.ok", 1'b1, 32'h3004, 32'h3333_4444, 5'd0, 2'd1);
        pop_one("t6.ok");
        fetch_one(32'hFFFF_FFF8, 32'h5555_6666);
        chk_head("t6.wrap", 1'b1, 32'hFFFF_FFF8, 32'h0, 5'd4, 2'd1);
        chk("t6.wrap0", pc8_out, 32'h0);
        pop_one("t6.wrap");
`else
        fetch_one(32'h3002, 32'hFFFF_FFFF);
        chk_head("t6.nochk", 1'b1, 32'h3002, 32'hFFFF_FFFF, 5'd0, 2'd1);
        pop_one("t6.nochk");
        fetch_one(32'h7000, 32'h1234_5678);
        chk_head("t6.nochk_hi", 1'b1, 32'h7000, 32'h1234_5678, 5'd0, 2'd1);
        pop_one("t6.nochk_hi");
        fetch_one(32'hFFFF_FFF8, 32'h5555_6666);
        chk_head("t6.wrap", 1'b1, 32'hFFFF_FFF8, 32'h5555_6666, 5'd0, 2'd1);
        chk("t6.wrap0", pc8_out, 32'h0);
        pop_one("t6.wrap");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
